gene_pair_sched: RTL

- Crossover alignment scheduler that feeds pe_front_end.
- Reads two parent genomes from two gene buffers. Each genome is sorted ascending by innovation id.
- Merge-aligns the genes by innovation id and issues one gene pair per handshake on the gene1_in/gene2_in side of the PE front end.
- Marks any missing (disjoint/excess) slot as a bubble.

---
 rtl/gene_pair_sched_if.sv | 31 +++
 rtl/gene_pair_sched.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/gene_pair_sched_if.sv
// Gene-buffer read ports and aligned gene-pair stream between gene_pair_sched and its neighbours.
// master = scheduler side, slave = buffer/PE side.
interface gene_pair_sched_if #(
   parameter int unsigned GENE_SZ = 64,
   parameter int unsigned ADDR_W  = 8
) ();
   logic               rd_en1;
   logic [ADDR_W-1:0]  rd_addr1;
   logic [GENE_SZ-1:0] rd_data1;
   logic               rd_en2;
   logic [ADDR_W-1:0]  rd_addr2;
   logic [GENE_SZ-1:0] rd_data2;
   logic               out_valid;
   logic               out_ready;
   logic [GENE_SZ-1:0] gene1_out;
   logic [GENE_SZ-1:0] gene2_out;
   logic               bubble1;
   logic               bubble2;

   modport master (
      output rd_en1, rd_addr1, rd_en2, rd_addr2,
      output out_valid, gene1_out, gene2_out, bubble1, bubble2,
      input  rd_data1, rd_data2, out_ready
   );

   modport slave (
      input  rd_en1, rd_addr1, rd_en2, rd_addr2,
      input  out_valid, gene1_out, gene2_out, bubble1, bubble2,
      output rd_data1, rd_data2, out_ready
   );
endinterface

// File: rtl/gene_pair_sched.sv
// Crossover alignment scheduler: merges two innovation-sorted genomes into gene pairs with bubbles.
// Optional XOVER_DROP_P2_EN: parent-2-only genes are consumed silently instead of presented.
module gene_pair_sched #(
   parameter int unsigned GENE_SZ = 64,
   parameter int unsigned ATTR_SZ = 8,
   parameter int unsigned ADDR_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] len1,
   input  logic [ADDR_W-1:0] len2,
   gene_pair_sched_if.master bus,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   pair_cnt
);
   localparam int unsigned CNT_W = ADDR_W + 1;
`ifdef XOVER_DROP_P2_EN
   localparam bit DROP_P2 = 1'b1;
`else
   localparam bit DROP_P2 = 1'b0;
`endif

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CAP, S_EMIT, S_FIN} state_e;

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  len1_q, len1_d, len2_q, len2_d;
   logic [ADDR_W-1:0]  idx1_q, idx1_d, idx2_q, idx2_d;
   logic [GENE_SZ-1:0] h1_q, h1_d, h2_q, h2_d;
   logic               hv1_q, hv1_d, hv2_q, hv2_d;
   logic               pend1_q, pend1_d, pend2_q, pend2_d;
   logic [CNT_W-1:0]   pair_cnt_q, pair_cnt_d;
   logic               rd_en1_q, rd_en1_d, rd_en2_q, rd_en2_d;
   logic [ADDR_W-1:0]  rd_addr1_q, rd_addr1_d, rd_addr2_q, rd_addr2_d;
   logic               out_valid_q, out_valid_d;
   logic [GENE_SZ-1:0] gene1_q, gene1_d, gene2_q, gene2_d;
   logic               bub1_q, bub1_d, bub2_q, bub2_d;
   logic               busy_q, busy_d, done_q, done_d;
   logic [1:0]         sel_c, sel_n_c;
   logic               drop_c, drop_n_c, fire_c;

   // Which heads an EMIT consumes: bit0 = parent 1, bit1 = parent 2.
   function automatic logic [1:0] pick(input logic v1, input logic v2,
                                       input logic [ATTR_SZ-1:0] i1, input logic [ATTR_SZ-1:0] i2);
      logic [1:0] sel;
      sel = {v2, v1};
      if (v1 && v2) begin
         if (i1 < i2)      sel = 2'b01;
         else if (i2 < i1) sel = 2'b10;
      end
      return sel;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         len1_q      <= '0;
         len2_q      <= '0;
         idx1_q      <= '0;
         idx2_q      <= '0;
         h1_q        <= '0;
         h2_q        <= '0;
         hv1_q       <= 1'b0;
         hv2_q       <= 1'b0;
         pend1_q     <= 1'b0;
         pend2_q     <= 1'b0;
         pair_cnt_q  <= '0;
         rd_en1_q    <= 1'b0;
         rd_en2_q    <= 1'b0;
         rd_addr1_q  <= '0;
         rd_addr2_q  <= '0;
         out_valid_q <= 1'b0;
         gene1_q     <= '0;
         gene2_q     <= '0;
         bub1_q      <= 1'b0;
         bub2_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         len1_q      <= len1_d;
         len2_q      <= len2_d;
         idx1_q      <= idx1_d;
         idx2_q      <= idx2_d;
         h1_q        <= h1_d;
         h2_q        <= h2_d;
         hv1_q       <= hv1_d;
         hv2_q       <= hv2_d;
         pend1_q     <= pend1_d;
         pend2_q     <= pend2_d;
         pair_cnt_q  <= pair_cnt_d;
         rd_en1_q    <= rd_en1_d;
         rd_en2_q    <= rd_en2_d;
         rd_addr1_q  <= rd_addr1_d;
         rd_addr2_q  <= rd_addr2_d;
         out_valid_q <= out_valid_d;
         gene1_q     <= gene1_d;
         gene2_q     <= gene2_d;
         bub1_q      <= bub1_d;
         bub2_q      <= bub2_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Next state; registered outputs are derived from next-state values so they line up with the state.
   always_comb begin
      state_d     = state_q;
      len1_d      = len1_q;
      len2_d      = len2_q;
      idx1_d      = idx1_q;
      idx2_d      = idx2_q;
      h1_d        = h1_q;
      h2_d        = h2_q;
      hv1_d       = hv1_q;
      hv2_d       = hv2_q;
      pend1_d     = pend1_q;
      pend2_d     = pend2_q;
      pair_cnt_d  = pair_cnt_q;
      rd_en1_d    = 1'b0;
      rd_en2_d    = 1'b0;
      rd_addr1_d  = rd_addr1_q;
      rd_addr2_d  = rd_addr2_q;
      out_valid_d = 1'b0;
      gene1_d     = '0;
      gene2_d     = '0;
      bub1_d      = 1'b0;
      bub2_d      = 1'b0;
      sel_n_c     = 2'b00;
      drop_n_c    = 1'b0;
      sel_c       = pick(hv1_q, hv2_q, h1_q[GENE_SZ-1 -: ATTR_SZ], h2_q[GENE_SZ-1 -: ATTR_SZ]);
      drop_c      = DROP_P2 && (sel_c == 2'b10);
      fire_c      = (state_q == S_EMIT) && (drop_c || (out_valid_q && bus.out_ready));

      case (state_q)
         S_IDLE: begin
            if (start) begin
               len1_d     = len1;
               len2_d     = len2;
               idx1_d     = '0;
               idx2_d     = '0;
               hv1_d      = 1'b0;
               hv2_d      = 1'b0;
               pair_cnt_d = '0;
               state_d    = ((len1 == '0) && (len2 == '0)) ? S_FIN : S_LOAD;
            end
         end
         S_LOAD: state_d = S_CAP;
         S_CAP: begin
            if (pend1_q) begin
               h1_d  = bus.rd_data1;
               hv1_d = 1'b1;
            end
            if (pend2_q) begin
               h2_d  = bus.rd_data2;
               hv2_d = 1'b1;
            end
            pend1_d = 1'b0;
            pend2_d = 1'b0;
            state_d = (hv1_d || hv2_d) ? S_EMIT : S_FIN;
         end
         S_EMIT: begin
            if (fire_c) begin
               if (sel_c[0]) hv1_d = 1'b0;
               if (sel_c[1]) hv2_d = 1'b0;
               if (!drop_c) pair_cnt_d = pair_cnt_q + CNT_W'(1);
               if ((sel_c[0] && (idx1_q < len1_q)) || (sel_c[1] && (idx2_q < len2_q)))
                  state_d = S_LOAD;
               else if (hv1_d || hv2_d)
                  state_d = S_EMIT;
               else
                  state_d = S_FIN;
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Refill each empty head that still has genes left.
      if (state_d == S_LOAD) begin
         if (!hv1_d && (idx1_d < len1_d)) begin
            rd_en1_d   = 1'b1;
            rd_addr1_d = idx1_d;
            idx1_d     = idx1_d + ADDR_W'(1);
            pend1_d    = 1'b1;
         end
         if (!hv2_d && (idx2_d < len2_d)) begin
            rd_en2_d   = 1'b1;
            rd_addr2_d = idx2_d;
            idx2_d     = idx2_d + ADDR_W'(1);
            pend2_d    = 1'b1;
         end
      end

      if (state_d == S_EMIT) begin
         sel_n_c  = pick(hv1_d, hv2_d, h1_d[GENE_SZ-1 -: ATTR_SZ], h2_d[GENE_SZ-1 -: ATTR_SZ]);
         drop_n_c = DROP_P2 && (sel_n_c == 2'b10);
         if (!drop_n_c) begin
            out_valid_d = 1'b1;
            gene1_d     = sel_n_c[0] ? h1_d : '0;
            gene2_d     = sel_n_c[1] ? h2_d : '0;
            bub1_d      = !sel_n_c[0];
            bub2_d      = !sel_n_c[1];
         end
      end

      busy_d = (state_d != S_IDLE);
      done_d = (state_q == S_FIN);
   end

   assign bus.rd_en1    = rd_en1_q;
   assign bus.rd_addr1  = rd_addr1_q;
   assign bus.rd_en2    = rd_en2_q;
   assign bus.rd_addr2  = rd_addr2_q;
   assign bus.out_valid = out_valid_q;
   assign bus.gene1_out = gene1_q;
   assign bus.gene2_out = gene2_q;
   assign bus.bubble1   = bub1_q;
   assign bus.bubble2   = bub2_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign pair_cnt      = pair_cnt_q;
endmodule
